// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, counts retired instructions and halts on bad opcodes.
module rv_mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state_o,
    output logic [31:0] instret
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_WB_ALU   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_WB_MEM   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;
    logic [6:0]  opcode;
    logic        unused_instr;

    logic       pc_we_c, ir_we_c, mem_req_c, mem_we_c, mem_addr_src_c, rf_we_c, alu_b_sel_c;
    logic [1:0] pc_src_c, wb_sel_c, alu_a_sel_c, alu_op_c;

    assign opcode       = instr[6:0];
    assign unused_instr = ^instr[31:7];

    always_comb begin
        state_d        = state_q;
        pc_we_c        = 1'b0;
        pc_src_c       = 2'b00;
        ir_we_c        = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_src_c = 1'b0;
        rf_we_c        = 1'b0;
        wb_sel_c       = 2'b00;
        alu_a_sel_c    = 2'b00;
        alu_b_sel_c    = 1'b0;
        alu_op_c       = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = S_EXEC;
                    OP_LOAD, OP_STORE:            state_d = S_MEM_ADDR;
                    OP_BR:                        state_d = S_BRANCH;
                    OP_JAL:                       state_d = S_JAL;
                    OP_JALR:                      state_d = S_JALR;
                    default:                      state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC: begin
                // Only the four ALU-class opcodes reach here; the default arm is AUIPC.
                case (opcode)
                    OP_R: alu_op_c = 2'b01;
                    OP_I: begin
                        alu_b_sel_c = 1'b1;
                        alu_op_c    = 2'b01;
                    end
                    OP_LUI: begin
                        alu_a_sel_c = 2'b10;
                        alu_b_sel_c = 1'b1;
                    end
                    default: begin
                        alu_a_sel_c = 2'b01;
                        alu_b_sel_c = 1'b1;
                    end
                endcase
                state_d = S_WB_ALU;
            end
            S_WB_ALU: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_b_sel_c = 1'b1;
                state_d     = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_c      = 1'b1;
                mem_addr_src_c = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                rf_we_c  = 1'b1;
                wb_sel_c = 2'b01;
                pc_we_c  = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_c      = 1'b1;
                mem_we_c       = 1'b1;
                mem_addr_src_c = 1'b1;
                if (mem_ready) begin
                    pc_we_c = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_op_c = 2'b10;
                pc_we_c  = 1'b1;
                pc_src_c = br_taken ? 2'b01 : 2'b00;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                rf_we_c  = 1'b1;
                wb_sel_c = 2'b10;
                pc_we_c  = 1'b1;
                pc_src_c = 2'b01;
                state_d  = S_FETCH;
            end
            S_JALR: begin
                alu_b_sel_c = 1'b1;
                rf_we_c     = 1'b1;
                wb_sel_c    = 2'b10;
                pc_we_c     = 1'b1;
                pc_src_c    = 2'b10;
                state_d     = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_ILLEGAL;
        endcase
    end

    always_comb begin
        instret_d = instret_q + {31'd0, pc_we_c};
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Everything is forced low while reset is held, aborting any transaction at once.
    assign pc_we        = rst_n & pc_we_c;
    assign pc_src       = rst_n ? pc_src_c : 2'b00;
    assign ir_we        = rst_n & ir_we_c;
    assign mem_req      = rst_n & mem_req_c;
    assign mem_we       = rst_n & mem_we_c;
    assign mem_addr_src = rst_n & mem_addr_src_c;
    assign rf_we        = rst_n & rf_we_c;
    assign wb_sel       = rst_n ? wb_sel_c : 2'b00;
    assign alu_a_sel    = rst_n ? alu_a_sel_c : 2'b00;
    assign alu_b_sel    = rst_n & alu_b_sel_c;
    assign alu_op       = rst_n ? alu_op_c : 2'b00;
    assign illegal      = rst_n & illegal_q;
    assign state_o      = rst_n ? state_q : 4'd0;
    assign instret      = rst_n ? instret_q : 32'd0;
endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed bench for rv_mc_ctrl: per-cycle state and control-bundle checks
// for each instruction class, memory waits, illegal halt, counter wrap and reset abort.
module tb_rv_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, ir_we, mem_req, mem_we, mem_addr_src, rf_we, alu_b_sel, illegal;
    logic [1:0]  pc_src, wb_sel, alu_a_sel, alu_op;
    logic [3:0]  state_o;
    logic [31:0] instret;
    logic [15:0] ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [15:0] PW     = 16'h8000;
    localparam logic [15:0] PS_ALU = 16'h4000;
    localparam logic [15:0] PS_IMM = 16'h2000;
    localparam logic [15:0] IR     = 16'h1000;
    localparam logic [15:0] MR     = 16'h0800;
    localparam logic [15:0] MW     = 16'h0400;
    localparam logic [15:0] MA     = 16'h0200;
    localparam logic [15:0] RW     = 16'h0100;
    localparam logic [15:0] WB_PC4 = 16'h0080;
    localparam logic [15:0] WB_MEM = 16'h0040;
    localparam logic [15:0] A_ZERO = 16'h0020;
    localparam logic [15:0] A_PC   = 16'h0010;
    localparam logic [15:0] B_IMM  = 16'h0008;
    localparam logic [15:0] OP_CMP = 16'h0004;
    localparam logic [15:0] OP_F   = 16'h0002;
    localparam logic [15:0] ILL    = 16'h0001;

    rv_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_src(mem_addr_src), .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op(alu_op), .illegal(illegal), .state_o(state_o),
        .instret(instret)
    );

    assign ctrl = {pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_src, rf_we,
                   wb_sel, alu_a_sel, alu_b_sel, alu_op, illegal};

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 16'h0 || state_o !== 4'd0 || instret !== 32'd0)
            $display("FAIL reset_hold: ctrl=%h state=%0d instret=%0d, want 0/0/0", ctrl, state_o, instret);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (ctrl !== 16'h0 || state_o !== 4'd0)
            $display("FAIL reset_hold2: ctrl=%h state=%0d, want 0/0", ctrl, state_o);
        else n_pass++;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== MR || state_o !== 4'd0 || instret !== 32'd0)
            $display("FAIL reset_release: ctrl=%h state=%0d instret=%0d, want %h/0/0", ctrl, state_o, instret, MR);
        else n_pass++;
    endtask

    task automatic test_rtype();
        logic [3:0]  es [4];
        logic [15:0] ec [4];
        instr = 32'h002081B3;
        es = '{4'd0, 4'd1, 4'd2, 4'd3};
        ec = '{IR | MR, 16'h0, OP_F, PW | RW};
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (state_o !== es[i] || ctrl !== ec[i])
                $display("FAIL rtype c%0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i, state_o, ctrl, es[i], ec[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (state_o !== 4'd0 || instret !== 32'd1)
            $display("FAIL rtype_end: state=%0d instret=%0d, want 0/1", state_o, instret);
        else n_pass++;
    endtask

    task automatic test_load_wait();
        logic [3:0]  es [8];
        logic [15:0] ec [8];
        logic [7:0]  rdy;
        instr = 32'h0000A103;
        es  = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6};
        ec  = '{IR | MR, 16'h0, B_IMM, MR | MA, MR | MA, MR | MA, MR | MA, PW | RW | WB_MEM};
        rdy = 8'b1100_0111;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            n_checks++;
            if (state_o !== es[i] || ctrl !== ec[i])
                $display("FAIL load c%0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i, state_o, ctrl, es[i], ec[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (state_o !== 4'd0 || instret !== 32'd2)
            $display("FAIL load_end: state=%0d instret=%0d, want 0/2", state_o, instret);
        else n_pass++;
    endtask

    task automatic test_store();
        logic [3:0]  es [4];
        logic [15:0] ec [4];
        instr = 32'h0020A023;
        es = '{4'd0, 4'd1, 4'd4, 4'd7};
        ec = '{IR | MR, 16'h0, B_IMM, PW | MR | MW | MA};
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (state_o !== es[i] || ctrl !== ec[i])
                $display("FAIL store c%0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i, state_o, ctrl, es[i], ec[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (state_o !== 4'd0 || instret !== 32'd3)
            $display("FAIL store_end: state=%0d instret=%0d, want 0/3", state_o, instret);
        else n_pass++;
    endtask

    task automatic test_branch();
        logic [15:0] ec [2][3];
        logic [31:0] exp_ret;
        instr = 32'h00208463;
        ec[0] = '{IR | MR, 16'h0, PW | PS_IMM | OP_CMP};
        ec[1] = '{IR | MR, 16'h0, PW | OP_CMP};
        exp_ret = 32'd3;
        for (int t = 0; t < 2; t++) begin
            exp_ret++;
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'b1;
                // Hold br_taken high outside BRANCH so only the BRANCH cycle may react.
                br_taken = (i < 2) ? 1'b1 : (t == 0);
                #1;
                n_checks++;
                if (state_o !== ((i == 2) ? 4'd8 : i[3:0]) || ctrl !== ec[t][i])
                    $display("FAIL branch%0d c%0d: state=%0d ctrl=%h, want ctrl=%h", t, i, state_o, ctrl, ec[t][i]);
                else n_pass++;
                @(posedge clk); #1;
            end
            n_checks++;
            if (state_o !== 4'd0 || instret !== exp_ret)
                $display("FAIL branch%0d_end: state=%0d instret=%0d, want 0/%0d", t, state_o, instret, exp_ret);
            else n_pass++;
        end
        br_taken = 1'b0;
    endtask

    task automatic test_jalr();
        logic [3:0]  es [3];
        logic [15:0] ec [3];
        instr = 32'h000080E7;
        es = '{4'd0, 4'd1, 4'd10};
        ec = '{IR | MR, 16'h0, PW | PS_ALU | RW | WB_PC4 | B_IMM};
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1;
            #1;
            n_checks++;
            if (state_o !== es[i] || ctrl !== ec[i])
                $display("FAIL jalr c%0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i, state_o, ctrl, es[i], ec[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (state_o !== 4'd0 || instret !== 32'd6)
            $display("FAIL jalr_end: state=%0d instret=%0d, want 0/6", state_o, instret);
        else n_pass++;
    endtask

    task automatic test_jal_wrap();
        instr = 32'h0000006F;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        n_checks++;
        if (state_o !== 4'd1 || instret !== 32'hFFFF_FFFF)
            $display("FAIL jal_preload: state=%0d instret=%h, want 1/ffffffff", state_o, instret);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 4'd9 || ctrl !== (PW | PS_IMM | RW | WB_PC4) || instret !== 32'hFFFF_FFFF)
            $display("FAIL jal_exec: state=%0d ctrl=%h instret=%h, want 9/%h/ffffffff",
                     state_o, ctrl, instret, PW | PS_IMM | RW | WB_PC4);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 4'd0 || instret !== 32'd0)
            $display("FAIL jal_wrap: state=%0d instret=%h, want 0/00000000", state_o, instret);
        else n_pass++;
    endtask

    task automatic test_illegal();
        instr = 32'h0000007F;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            n_checks++;
            if (state_o !== 4'd15 || ctrl !== ILL)
                $display("FAIL illegal c%0d: state=%0d ctrl=%h, want 15/%h", i, state_o, ctrl, ILL);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || ctrl !== MR || instret !== 32'd0)
            $display("FAIL illegal_clear: state=%0d ctrl=%h instret=%0d, want 0/%h/0", state_o, ctrl, instret, MR);
        else n_pass++;
    endtask

    task automatic test_reset_mid_store();
        logic [3:0]  es [6];
        logic [15:0] ec [6];
        logic [5:0]  rdy;
        instr = 32'h0020A023;
        es  = '{4'd0, 4'd0, 4'd1, 4'd4, 4'd7, 4'd7};
        ec  = '{MR, IR | MR, 16'h0, B_IMM, MR | MW | MA, MR | MW | MA};
        rdy = 6'b00_0110;
        for (int i = 0; i < 6; i++) begin
            mem_ready = rdy[i];
            #1;
            n_checks++;
            if (state_o !== es[i] || ctrl !== ec[i])
                $display("FAIL store_wait c%0d: state=%0d ctrl=%h, want state=%0d ctrl=%h", i, state_o, ctrl, es[i], ec[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 16'h0)
            $display("FAIL abort_cycle: ctrl=%h, want 0000", ctrl);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || ctrl !== MR || instret !== 32'd0)
            $display("FAIL abort_after: state=%0d ctrl=%h instret=%0d, want 0/%h/0", state_o, ctrl, instret, MR);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch();
        test_jalr();
        test_jal_wrap();
        test_illegal();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv_mc_ctrl.md
# rv_mc_ctrl

Multi-cycle control FSM for the RV32I core. Sequences the shared datapath (instruction/data memory port, register file, ALU, immediate generator, PC) one instruction at a time by decoding the instruction-register opcode, and drives every datapath select and write strobe. Counts retired instructions and halts on an unsupported opcode.

## Interface
- No parameters.
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- instr  in  32  instruction register contents; valid from DECODE onward.
- br_taken  in  1  branch compare result for current funct3 (ALU compare output).
- mem_ready  in  1  memory-port completion; meaningful only while mem_req=1.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  00 PC+4, 01 PC+imm (branch adder), 10 live ALU result & ~1.
- ir_we  out  1  instruction register write.
- mem_req  out  1  memory request; mem_we  out  1  store when 1.
- mem_addr_src  out  1  0 PC, 1 ALUOut register.
- rf_we  out  1  register-file write.
- wb_sel  out  2  00 ALUOut, 01 memory read data, 10 PC+4.
- alu_a_sel  out  2  00 rs1, 01 PC, 10 zero.
- alu_b_sel  out  1  0 rs2, 1 imm.
- alu_op  out  2  00 add, 01 funct3/funct7 decode, 10 compare.
- illegal  out  1  sticky halt flag.
- state_o  out  4  current state encoding.
- instret  out  32  retired-instruction count.

## Operation
- Datapath latches ALU result into ALUOut every cycle; PC is held for the whole instruction and written only in the final state.
- States/encoding: FETCH 0, DECODE 1, EXEC 2, WB_ALU 3, MEM_ADDR 4, MEM_RD 5, WB_MEM 6, MEM_WR 7, BRANCH 8, JAL 9, JALR 10, ILLEGAL 15.
- FETCH: mem_req=1, mem_addr_src=0; stay until mem_ready; on mem_ready ir_we=1, go DECODE.
- DECODE on instr[6:0]: 0110011/0010011/0110111/0010111 -> EXEC; 0000011/0100011 -> MEM_ADDR; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; any other -> ILLEGAL.
- EXEC: R: a=rs1,b=rs2,op=01; I-ALU: a=rs1,b=imm,op=01; LUI: a=zero,b=imm,op=00; AUIPC: a=PC,b=imm,op=00. -> WB_ALU.
- WB_ALU: rf_we=1, wb_sel=00, pc_we=1, pc_src=00 -> FETCH.
- MEM_ADDR: a=rs1,b=imm,op=00; -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, mem_addr_src=1; wait for mem_ready -> WB_MEM. WB_MEM: rf_we=1, wb_sel=01, pc_we=1, pc_src=00 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, mem_addr_src=1; on mem_ready pc_we=1, pc_src=00 -> FETCH.
- BRANCH: a=rs1,b=rs2,op=10; pc_we=1, pc_src = br_taken ? 01 : 00 -> FETCH.
- JAL: rf_we=1, wb_sel=10, pc_we=1, pc_src=01 -> FETCH.
- JALR: a=rs1,b=imm,op=00; rf_we=1, wb_sel=10, pc_we=1, pc_src=10 -> FETCH.
- ILLEGAL: illegal=1, all strobes 0, remains until reset.
- instret increments by 1 on every cycle with pc_we=1; wraps 0xFFFFFFFF -> 0.
- Unlisted selects are 0 in each state.

## Timing
- Reset: while rst_n=0 all outputs 0 (strobes gated); on the edge state=FETCH, instret=0, illegal=0. First cycle after release: mem_req=1.
- Reset mid-transaction aborts immediately: no pc_we/rf_we/ir_we; mem_req drops in the reset cycle.
- mem_req, mem_we, mem_addr_src held stable until the mem_ready cycle; mem_ready with mem_req=0 ignored. mem_ready may be high in the first request cycle (zero wait).
- ir_we, pc_we in MEM_WR, and pc_src in BRANCH are Mealy (same-cycle on mem_ready/br_taken); all else Moore.
- Minimum cycles (zero wait): R/I/LUI/AUIPC 4, load 5, store 4, branch/JAL/JALR 3. Each memory wait cycle adds 1.

## Test plan
- Reset then R-type 0x002081B3 (add), mem_ready=1 always -> states 0,1,2,3,0; rf_we and pc_we in cycle 4 only, instret=1.
- Load 0x0000A103 with mem_ready low 3 cycles in MEM_RD -> mem_req/mem_addr_src=1 held 4 cycles, WB_MEM wb_sel=01, total 8 cycles.
- Branch 0x00208463 with br_taken=1 then 0 -> pc_src=01 then 00, pc_we=1 in BRANCH, 3 cycles each.
- JALR 0x000080E7 -> rf_we=1, wb_sel=10, pc_src=10, alu_b_sel=1 in one cycle.
- Opcode 0x0000007F -> ILLEGAL, illegal=1 sticky, no further mem_req for 20 cycles; rst_n=0 one cycle clears it.
- Preload instret near wrap via 2^32 JALs (or force) at 0xFFFFFFFF, retire one -> 0; rst_n low during MEM_WR wait -> no pc_we, state 0 after.
